// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// Module   : stopwatch_ctrl
// Brief    : M:SS.t stopwatch sequencer with run/pause FSM, tick prescaler,
//            BCD carry chain, lap-hold capture and sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_ctrl #(
  parameter int TICK_DIV = 5000000,
  parameter int PW       = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] disp,
  output logic        running,
  output logic        paused,
  output logic        held,
  output logic        ovf,
  output logic        tick
);

  localparam logic [1:0]    S_IDLE  = 2'd0;
  localparam logic [1:0]    S_RUN   = 2'd1;
  localparam logic [1:0]    S_PAUSE = 2'd2;
  localparam logic [PW-1:0] C_TOP   = PW'(TICK_DIV - 1);

  logic [1:0]    state_q, state_d;
  logic          running_q, running_d, paused_q, paused_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   live_q, live_d, lapr_q, lapr_d, disp_q, disp_d;
  logic          held_q, held_d, ovf_q, ovf_d, tick_q, tick_d;
  logic          w_adv, w_c1, w_c2, w_c3, w_wrap;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Priority: clear > stop > start.
  always_comb begin
    state_d = state_q;
    if (clear)                           state_d = S_IDLE;
    else if (stop && state_q == S_RUN)   state_d = S_PAUSE;
    else if (start && state_q != S_RUN)  state_d = S_RUN;
  end

  always_comb begin
    running_d = (state_d == S_RUN);
    paused_d  = (state_d == S_PAUSE);
  end

  // Carry chain keyed on the registered state so a stop on a tick edge still advances.
  assign w_adv  = (state_q == S_RUN) && (presc_q == C_TOP);
  assign w_c1   = w_adv && (live_q[3:0]   == 4'd9);
  assign w_c2   = w_c1  && (live_q[7:4]   == 4'd9);
  assign w_c3   = w_c2  && (live_q[11:8]  == 4'd5);
  assign w_wrap = w_c3  && (live_q[15:12] == 4'd9);

  always_comb begin
    presc_d = presc_q;
    live_d  = live_q;
    ovf_d   = ovf_q | w_wrap;
    tick_d  = w_adv & ~clear;
    held_d  = held_q;
    lapr_d  = lapr_q;
    if (clear) begin
      presc_d = '0;
      live_d  = '0;
      ovf_d   = 1'b0;
      held_d  = 1'b0;
      lapr_d  = '0;
    end else begin
      if (state_q == S_RUN) presc_d = w_adv ? '0 : presc_q + PW'(1);
      if (w_adv) live_d[3:0]   = w_c1   ? 4'd0 : live_q[3:0]   + 4'd1;
      if (w_c1)  live_d[7:4]   = w_c2   ? 4'd0 : live_q[7:4]   + 4'd1;
      if (w_c2)  live_d[11:8]  = w_c3   ? 4'd0 : live_q[11:8]  + 4'd1;
      if (w_c3)  live_d[15:12] = w_wrap ? 4'd0 : live_q[15:12] + 4'd1;
      if (lap) begin
        if (held_q) begin
          held_d = 1'b0;
        end else if (state_q == S_RUN) begin
          held_d = 1'b1;
          lapr_d = live_q;
        end
      end
    end
    disp_d = held_d ? lapr_d : live_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running_q <= 1'b0;
      paused_q  <= 1'b0;
      presc_q   <= '0;
      live_q    <= '0;
      lapr_q    <= '0;
      disp_q    <= '0;
      held_q    <= 1'b0;
      ovf_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      running_q <= running_d;
      paused_q  <= paused_d;
      presc_q   <= presc_d;
      live_q    <= live_d;
      lapr_q    <= lapr_d;
      disp_q    <= disp_d;
      held_q    <= held_d;
      ovf_q     <= ovf_d;
      tick_q    <= tick_d;
    end
  end

  assign disp    = disp_q;
  assign running = running_q;
  assign paused  = paused_q;
  assign held    = held_q;
  assign ovf     = ovf_q;
  assign tick    = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Brief    : Scoreboard bench for stopwatch_ctrl against a tenths-count model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1, start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [15:0] disp;
  logic        running, paused, held, ovf, tick;

  stopwatch_ctrl #(.TICK_DIV(TD), .PW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .disp(disp), .running(running), .paused(paused), .held(held), .ovf(ovf), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] disp;
    logic running, paused, held, ovf, tick;
  } obs_t;

  obs_t expq[$];
  obs_t mon_e, mon_a;
  int   n_tests = 0, n_fail = 0;

  // Model: elapsed time as a plain count of tenths, converted to BCD only for display.
  int m_state = M_IDLE, m_presc = 0, m_t = 0, m_lapt = 0;
  bit m_held = 0, m_ovf = 0, m_tick = 0;

  function automatic logic [15:0] to_bcd(int t);
    return {4'(t / 600), 4'((t / 100) % 6), 4'((t / 10) % 10), 4'(t % 10)};
  endfunction

  task automatic model_step(bit r, bit st, bit sp, bit cl, bit lp);
    bit adv;
    if (r || cl) begin
      m_state = M_IDLE; m_presc = 0; m_t = 0; m_lapt = 0;
      m_held = 0; m_ovf = 0; m_tick = 0;
      return;
    end
    adv = (m_state == M_RUN) && (m_presc == TD - 1);
    if (lp) begin
      if (m_held) m_held = 0;
      else if (m_state == M_RUN) begin m_held = 1; m_lapt = m_t; end
    end
    if (m_state == M_RUN) begin
      if (adv) begin
        m_presc = 0;
        m_t = m_t + 1;
        if (m_t == 6000) begin m_t = 0; m_ovf = 1; end
      end else m_presc = m_presc + 1;
    end
    m_tick = adv;
    if (sp && m_state == M_RUN)       m_state = M_PAUSE;
    else if (st && m_state != M_RUN)  m_state = M_RUN;
  endtask

  task automatic cycle(bit r, bit st, bit sp, bit cl, bit lp);
    obs_t e;
    rst = r; start = st; stop = sp; clear = cl; lap = lp;
    @(posedge clk);
    model_step(r, st, sp, cl, lp);
    e.disp    = to_bcd(m_held ? m_lapt : m_t);
    e.running = (m_state == M_RUN);
    e.paused  = (m_state == M_PAUSE);
    e.held    = m_held;
    e.ovf     = m_ovf;
    e.tick    = m_tick;
    expq.push_back(e);
    #1;
    rst = 0; start = 0; stop = 0; clear = 0; lap = 0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic expect_eq(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired, got m_t=%0d", nm, m_t);
  endtask

  task automatic run_to(int target, string nm);
    int guard = 0;
    while (m_t != target && guard < 30000) begin cycle(0, 0, 0, 0, 0); guard++; end
    if (m_t != target) timeout(nm);
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      mon_a = {disp, running, paused, held, ovf, tick};
      n_tests++;
      if (mon_a !== mon_e) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: got disp=%h run=%b pau=%b held=%b ovf=%b tick=%b, expected disp=%h run=%b pau=%b held=%b ovf=%b tick=%b",
                 $time, mon_a.disp, mon_a.running, mon_a.paused, mon_a.held, mon_a.ovf, mon_a.tick,
                 mon_e.disp, mon_e.running, mon_e.paused, mon_e.held, mon_e.ovf, mon_e.tick);
      end
    end
  end

  initial begin
    int s;
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    expect_eq("reset_outputs", 32'({disp, running, paused, held, ovf, tick}), 32'h0);

    // Basic counting from start at edge 0.
    cycle(0, 1, 0, 0, 0);
    idle(3);
    expect_eq("pre_first_tick", 32'(disp), 32'h0000);
    idle(1);
    expect_eq("first_tick_disp", 32'(disp), 32'h0001);
    expect_eq("first_tick_pulse", 32'({tick, running}), 32'h3);
    idle(36);
    expect_eq("edge40_disp", 32'(disp), 32'h0010);

    // Pause with a partial count, then resume.
    cycle(0, 0, 1, 0, 0);
    idle(20);
    expect_eq("paused_hold", 32'({disp, paused, tick}), 32'({16'h0010, 1'b1, 1'b0}));
    cycle(0, 1, 0, 0, 0);
    idle(2);
    expect_eq("resume_not_yet", 32'(disp), 32'h0010);
    idle(1);
    expect_eq("resume_advance", 32'(disp), 32'h0011);

    // Lap hold.
    run_to(12, "wait_0012");
    cycle(0, 0, 0, 0, 1);
    expect_eq("lap_capture", 32'({disp, held}), 32'({16'h0012, 1'b1}));
    idle(20);
    expect_eq("lap_frozen", 32'(disp), 32'h0012);
    cycle(0, 0, 0, 0, 1);
    expect_eq("lap_release", 32'({disp, held}), 32'({16'h0017, 1'b0}));

    // Priority and ignored commands.
    cycle(0, 1, 0, 1, 0);
    expect_eq("clear_over_start", 32'({disp, running, paused}), 32'h0);
    cycle(0, 1, 0, 0, 0);
    idle(1);
    cycle(0, 1, 0, 0, 0);
    idle(1);
    cycle(0, 0, 0, 0, 0);
    expect_eq("start_in_run_ignored", 32'(disp), 32'h0001);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 1, 0, 0);
    expect_eq("stop_in_idle", 32'({running, paused}), 32'h0);

    // Randomized command traffic.
    for (int i = 0; i < 2000; i++) begin
      s = int'($urandom_range(0, 299));
      cycle(s == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 40) == 0, $urandom_range(0, 9) == 0);
    end

    // Full carry chain and wrap, then lap and synchronous reset with flags set.
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0);
    run_to(5999, "wait_9599");
    expect_eq("pre_wrap", 32'(disp), 32'h9599);
    run_to(0, "wait_wrap");
    expect_eq("wrap", 32'({disp, ovf, running}), 32'({16'h0000, 1'b1, 1'b1}));
    idle(5);
    cycle(0, 0, 0, 0, 1);
    expect_eq("held_and_ovf", 32'({held, ovf}), 32'h3);
    cycle(1, 0, 0, 0, 0);
    expect_eq("rst_mid_run", 32'({disp, running, paused, held, ovf, tick}), 32'h0);
    cycle(1, 1, 0, 0, 0);
    expect_eq("rst_with_start", 32'({running, paused}), 32'h0);

    // Second wrap, then clear drops ovf.
    cycle(0, 1, 0, 0, 0);
    run_to(5999, "wait_9599_b");
    run_to(0, "wait_wrap_b");
    expect_eq("wrap_b_ovf", 32'(ovf), 32'h1);
    cycle(0, 0, 0, 1, 0);
    expect_eq("clear_ovf", 32'({disp, running, paused, ovf}), 32'h0);
    idle(3);

    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
